// File: rtl/rfsoc_config_pkg.sv
// rtl/rfsoc_config_pkg.sv - shared state encodings and default widths for the sample path
package rfsoc_config;

  typedef enum logic [1:0] {BS_IDLE, BS_SEND, BS_GAP} burst_state_t;

  localparam int AXIS_DW     = 16;
  localparam int BURST_LEN_W = 8;

endpackage

// File: rtl/axis_burst_source.sv
// rtl/axis_burst_source.sv - AXI-Stream master emitting repeated arithmetic bursts separated by idle gaps
module axis_burst_source
  import rfsoc_config::*;
#(
  parameter int DATA_WIDTH = AXIS_DW,
  parameter int LEN_WIDTH  = BURST_LEN_W,
  parameter int GAP_WIDTH  = 8,
  parameter int REP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cfg_first,
  input  logic [DATA_WIDTH-1:0] cfg_step,
  input  logic [LEN_WIDTH-1:0]  cfg_burst_len,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [REP_WIDTH-1:0]  cfg_repeat,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  burst_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [REP_WIDTH-1:0]  burst_q, burst_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [REP_WIDTH-1:0]  rep_q, rep_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;

  logic                  hs;
  logic                  abort_req;
  logic [REP_WIDTH-1:0]  burst_inc;

  always_comb begin
    state_d      = state_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    beat_d       = beat_q;
    burst_d      = burst_q;
    gap_cnt_d    = gap_cnt_q;
    step_d       = step_q;
    len_d        = len_q;
    gap_d        = gap_q;
    rep_d        = rep_q;
    abort_pend_d = abort_pend_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    hs           = tvalid_q & m_axis_tready;
    abort_req    = abort | abort_pend_q;
    burst_inc    = burst_q + REP_WIDTH'(1);

    case (state_q)
      BS_IDLE: begin
        abort_pend_d = 1'b0;
        if (start && !abort) begin
          step_d   = cfg_step;
          len_d    = cfg_burst_len;
          gap_d    = cfg_gap;
          rep_d    = cfg_repeat;
          tdata_d  = cfg_first;
          tvalid_d = 1'b1;
          beat_d   = '0;
          burst_d  = '0;
          busy_d   = 1'b1;
          state_d  = BS_SEND;
        end
      end
      BS_SEND: begin
        abort_pend_d = abort_req;
        if (hs) begin
          // The word sequence runs on across burst boundaries; only the beat index restarts.
          tdata_d = tdata_q + step_q;
          beat_d  = beat_q + LEN_WIDTH'(1);
          if (tlast_q) begin
            burst_d = burst_inc;
            beat_d  = '0;
          end
          if (tlast_q && rep_q != '0 && burst_inc == rep_q) begin
            state_d      = BS_IDLE;
            tvalid_d     = 1'b0;
            busy_d       = 1'b0;
            abort_pend_d = 1'b0;
            done_d       = 1'b1;
          end else if (abort_req) begin
            state_d      = BS_IDLE;
            tvalid_d     = 1'b0;
            busy_d       = 1'b0;
            abort_pend_d = 1'b0;
            aborted_d    = 1'b1;
          end else if (tlast_q && gap_q != '0) begin
            state_d   = BS_GAP;
            tvalid_d  = 1'b0;
            gap_cnt_d = gap_q;
          end
        end
      end
      BS_GAP: begin
        if (abort_req) begin
          state_d      = BS_IDLE;
          busy_d       = 1'b0;
          abort_pend_d = 1'b0;
          aborted_d    = 1'b1;
        end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
          state_d  = BS_SEND;
          tvalid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      default: begin
        state_d  = BS_IDLE;
        tvalid_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    // burst_len of 0 makes len-1 wrap to all ones, giving 2**LEN_WIDTH beats.
    tlast_d = tvalid_d & (beat_d == len_d - LEN_WIDTH'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BS_IDLE;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      beat_q       <= '0;
      burst_q      <= '0;
      gap_cnt_q    <= '0;
      step_q       <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      rep_q        <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      beat_q       <= beat_d;
      burst_q      <= burst_d;
      gap_cnt_q    <= gap_cnt_d;
      step_q       <= step_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      rep_q        <= rep_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_burst_source.sv
// tb/tb_axis_burst_source.sv - directed self-checking bench for axis_burst_source
module tb_axis_burst_source;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_first = '0;
  logic [15:0] cfg_step = '0;
  logic [7:0]  cfg_burst_len = '0;
  logic [7:0]  cfg_gap = '0;
  logic [7:0]  cfg_repeat = '0;
  logic        tready = 1'b0;
  logic        busy, done, aborted;
  logic [15:0] tdata;
  logic        tvalid, tlast;

  axis_burst_source dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_first     (cfg_first),
    .cfg_step      (cfg_step),
    .cfg_burst_len (cfg_burst_len),
    .cfg_gap       (cfg_gap),
    .cfg_repeat    (cfg_repeat),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] q_data[$];
  logic        q_last[$];
  int          q_cyc[$];
  logic        done_seen, aborted_seen, busy_at_end, tvalid_at_end;
  int          end_cyc;
  int          both_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    done_seen = 0;
    aborted_seen = 0;
    busy_at_end = 1;
    tvalid_at_end = 1;
    end_cyc = -1;
  endtask

  // Samples the current cycle (just after a falling edge), then advances one cycle.
  task automatic step_cycle();
    if (tvalid && tready) begin
      q_data.push_back(tdata);
      q_last.push_back(tlast);
      q_cyc.push_back(cyc);
    end
    if (done && aborted) both_cnt++;
    if (done || aborted) begin
      done_seen = done_seen | done;
      aborted_seen = aborted_seen | aborted;
      busy_at_end = busy;
      tvalid_at_end = tvalid;
      end_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_burst(input logic [15:0] first, input logic [15:0] stp,
                             input logic [7:0] len, input logic [7:0] gap, input logic [7:0] rep);
    cfg_first = first;
    cfg_step = stp;
    cfg_burst_len = len;
    cfg_gap = gap;
    cfg_repeat = rep;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
  endtask

  task automatic run_until(input string tag, input int budget);
    int n = 0;
    while (!(done_seen || aborted_seen) && n < budget) begin
      step_cycle();
      n++;
    end
    check({tag, "_ended"}, 32'(done_seen | aborted_seen), 1);
  endtask

  task automatic check_seq(input string tag, input int n, input logic [15:0] first,
                           input logic [15:0] stp, input int len);
    check({tag, "_count"}, q_data.size(), n);
    for (int i = 0; i < q_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), q_data[i], 16'(first + stp * i));
      check($sformatf("%s_last%0d", tag, i), q_last[i], 32'((i % len) == len - 1));
    end
  endtask

  initial begin
    int unstable;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: single 8-beat burst, no backpressure
    clear_log();
    tready = 1'b1;
    start_burst(16'd1, 16'd1, 8'd8, 8'd0, 8'd1);
    check("t1_lat_tvalid", tvalid, 1);
    check("t1_lat_tdata", tdata, 1);
    check("t1_lat_busy", busy, 1);
    run_until("t1", 50);
    check_seq("t1", 8, 16'd1, 16'd1, 8);
    if (q_cyc.size() == 8) check("t1_consecutive", q_cyc[7] - q_cyc[0], 7);
    if (q_cyc.size() == 8) check("t1_done_lat", end_cyc - q_cyc[7], 1);
    check("t1_done", done_seen, 1);
    check("t1_busy_fall", busy_at_end, 0);

    // 2: held off by tready=0 for 100 cycles
    clear_log();
    tready = 1'b0;
    start_burst(16'd1, 16'd1, 8'd8, 8'd0, 8'd1);
    unstable = 0;
    for (int i = 0; i < 100; i++) begin
      if (!(tvalid === 1'b1 && tdata === 16'd1 && tlast === 1'b0)) unstable++;
      step_cycle();
    end
    check("t2_hold", unstable, 0);
    tready = 1'b1;
    run_until("t2", 50);
    check_seq("t2", 8, 16'd1, 16'd1, 8);
    check("t2_done", done_seen, 1);

    // 3: wrapping data, gap of 3, two bursts
    clear_log();
    start_burst(16'hFFFE, 16'd1, 8'd4, 8'd3, 8'd2);
    run_until("t3", 50);
    check_seq("t3", 8, 16'hFFFE, 16'd1, 4);
    if (q_cyc.size() == 8) check("t3_gap", q_cyc[4] - q_cyc[3], 4);
    if (q_cyc.size() == 8) check("t3_burst0_dense", q_cyc[3] - q_cyc[0], 3);
    check("t3_done", done_seen, 1);

    // 4: burst_len=0 means 256 beats
    clear_log();
    start_burst(16'd0, 16'd1, 8'd0, 8'd0, 8'd1);
    run_until("t4", 400);
    check_seq("t4", 256, 16'd0, 16'd1, 256);
    check("t4_done", done_seen, 1);

    // 5: endless run aborted while backpressured
    clear_log();
    start_burst(16'd10, 16'd2, 8'd4, 8'd0, 8'd0);
    step_cycle();
    step_cycle();
    tready = 1'b0;
    abort = 1'b1;
    step_cycle();
    abort = 1'b0;
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      if (!(tvalid === 1'b1 && tdata === 16'd14 && tlast === 1'b0 && aborted === 1'b0)) unstable++;
      step_cycle();
    end
    check("t5_hold", unstable, 0);
    tready = 1'b1;
    run_until("t5", 10);
    check("t5_count", q_data.size(), 3);
    if (q_data.size() == 3) check("t5_last_data", q_data[2], 16'd14);
    if (q_cyc.size() == 3) check("t5_abort_lat", end_cyc - q_cyc[2], 1);
    check("t5_aborted", aborted_seen, 1);
    check("t5_no_done", done_seen, 0);
    check("t5_busy", busy_at_end, 0);
    check("t5_tvalid", tvalid_at_end, 0);

    // 6a: start while busy is ignored
    clear_log();
    start_burst(16'd100, 16'd1, 8'd3, 8'd0, 8'd2);
    step_cycle();
    cfg_first = 16'd0;
    cfg_burst_len = 8'd1;
    cfg_repeat = 8'd5;
    cfg_gap = 8'd7;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    run_until("t6a", 30);
    check_seq("t6a", 6, 16'd100, 16'd1, 3);
    check("t6a_done", done_seen, 1);

    // 6b: abort together with start in IDLE
    abort = 1'b1;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    abort = 1'b0;
    check("t6b_busy", busy, 0);
    check("t6b_tvalid", tvalid, 0);
    step_cycle();
    check("t6b_tvalid2", tvalid, 0);

    // 6c: asynchronous reset mid-burst
    clear_log();
    start_burst(16'd0, 16'd1, 8'd8, 8'd0, 8'd0);
    step_cycle();
    check("t6c_pre_tvalid", tvalid, 1);
    #2 rst = 1'b0;
    #1;
    check("t6c_tvalid", tvalid, 0);
    check("t6c_busy", busy, 0);
    check("t6c_tdata", tdata, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check("no_done_and_aborted", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
